word_receiver: RTL and testbench

Parametrised serial-to-parallel receiver that shifts in WIDTH bits, one per sample strobe, while a frame enable is high. Unlike the plain byte shifter, it tracks its own bit count and supports MSB-first or LSB-first ordering. It presents each completed word on a valid/ready output register and flags overrun. It sits between the I2C bit-level front end and the byte/word consumers, such as the FNV hash core and the register file.

---
 rtl/word_receiver.sv | 106 ++++++++++
 tb/tb_word_receiver.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/word_receiver.sv
// Serial-to-parallel word receiver: assembles WIDTH bits per word and hands
// each completed word to a registered valid/ready output with a sticky overrun flag.
module word_receiver #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             sample,
    input  logic             in,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic [CW-1:0]    bit_count,
    output logic             busy,
    output logic             overrun
);
    // state     | meaning
    // SH_IDLE   | no bits of the current word received (bit_count == 0)
    // SH_SHIFT  | partial word in progress (bit_count > 0)
    // OUT_EMPTY | output register free
    // OUT_FULL  | completed word held, waiting for out_ready
    typedef enum logic {SH_IDLE, SH_SHIFT} sh_state_t;
    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    sh_state_t        sh_state_q;
    out_state_t       out_state_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] data_q;
    logic             ovr_q;
    logic             shift_en;
    logic             complete;

    // sr_d is also the finished word on a completing shift, current bit included.
    always_comb begin
        sr_d = {sr_q[WIDTH-2:0], in};
        if (!MSB_FIRST) begin
            sr_d = {in, sr_q[WIDTH-1:1]};
        end
    end

    assign cnt_d    = cnt_q + CW'(1);
    assign shift_en = enable && sample;
    assign complete = shift_en && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_state_q  <= SH_IDLE;
            out_state_q <= OUT_EMPTY;
            sr_q        <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
            ovr_q       <= 1'b0;
        end else begin
            if (!enable) begin
                sr_q       <= '0;
                cnt_q      <= '0;
                sh_state_q <= SH_IDLE;
                ovr_q      <= 1'b0;
            end else if (sample) begin
                if (complete) begin
                    sr_q       <= '0;
                    cnt_q      <= '0;
                    sh_state_q <= SH_IDLE;
                end else begin
                    sr_q       <= sr_d;
                    cnt_q      <= cnt_d;
                    sh_state_q <= SH_SHIFT;
                end
            end

            case (out_state_q)
                OUT_EMPTY: begin
                    if (complete) begin
                        data_q      <= sr_d;
                        out_state_q <= OUT_FULL;
                    end
                end
                OUT_FULL: begin
                    if (complete) begin
                        if (out_ready) begin
                            data_q <= sr_d;
                        end else begin
                            ovr_q <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_state_q <= OUT_EMPTY;
                    end
                end
                default: out_state_q <= OUT_EMPTY;
            endcase
        end
    end

    assign out_data  = data_q;
    assign out_valid = (out_state_q == OUT_FULL);
    assign bit_count = cnt_q;
    assign busy      = (sh_state_q == SH_SHIFT);
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_word_receiver.sv
// Directed bench for word_receiver: 8-bit MSB/LSB-first instances driven from
// a shared vector table, plus a 16-bit instance for streaming and async reset.
module tb_word_receiver;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, en8, smp8, din8, rdy8;
    logic [7:0] data_m, data_l;
    logic       valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;
    logic [2:0] cnt_m, cnt_l;

    logic        rst16, en16, smp16, din16, rdy16;
    logic [15:0] data16;
    logic        valid16, busy16, ovr16;
    logic [3:0]  cnt16;

    word_receiver #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(rst8), .enable(en8), .sample(smp8), .in(din8),
        .out_ready(rdy8), .out_data(data_m), .out_valid(valid_m),
        .bit_count(cnt_m), .busy(busy_m), .overrun(ovr_m));

    word_receiver #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(rst8), .enable(en8), .sample(smp8), .in(din8),
        .out_ready(rdy8), .out_data(data_l), .out_valid(valid_l),
        .bit_count(cnt_l), .busy(busy_l), .overrun(ovr_l));

    word_receiver #(.WIDTH(16), .MSB_FIRST(1'b1)) u_w16 (
        .clk(clk), .reset(rst16), .enable(en16), .sample(smp16), .in(din16),
        .out_ready(rdy16), .out_data(data16), .out_valid(valid16),
        .bit_count(cnt16), .busy(busy16), .overrun(ovr16));

    typedef struct {
        logic       en, smp, din, rdy;
        logic       v;
        logic [7:0] dm, dl;
        logic [2:0] c;
        logic       o;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic en, smp, din, rdy, v,
                                 input logic [7:0] dm, dl,
                                 input logic [2:0] c, input logic o);
        vec_t r;
        r.en = en; r.smp = smp; r.din = din; r.rdy = rdy;
        r.v = v; r.dm = dm; r.dl = dl; r.c = c; r.o = o;
        vecs.push_back(r);
    endfunction

    // Eight back-to-back strobes of w (sent MSB of w first); rows before the last
    // keep the base output state, the last row shows the post-completion state.
    function automatic void add_word(input logic [7:0] w, input logic rdy_last,
                                     input logic bv, input logic [7:0] bdm, bdl, input logic bo,
                                     input logic fv, input logic [7:0] fdm, fdl, input logic fo);
        for (int k = 0; k < 8; k++) begin
            if (k < 7) push(1'b1, 1'b1, w[7-k], 1'b0, bv, bdm, bdl, 3'(k + 1), bo);
            else       push(1'b1, 1'b1, w[0], rdy_last, fv, fdm, fdl, 3'd0, fo);
        end
    endfunction

    initial begin
        logic [15:0] w16;
        rst8 = 1'b1; en8 = 1'b0; smp8 = 1'b0; din8 = 1'b0; rdy8 = 1'b0;
        rst16 = 1'b1; en16 = 1'b0; smp16 = 1'b0; din16 = 1'b0; rdy16 = 1'b0;

        // idle row
        push(0, 0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0);
        // 0x12 stream: MSB-first 0x12, LSB-first 0x48, then one-cycle drain
        add_word(8'h12, 0, 0, 8'h00, 8'h00, 0, 1, 8'h12, 8'h48, 0);
        push(1, 0, 0, 1, 0, 8'h12, 8'h48, 3'd0, 0);
        // overrun: 0x12 then 0xFF with no drain
        add_word(8'h12, 0, 0, 8'h12, 8'h48, 0, 1, 8'h12, 8'h48, 0);
        add_word(8'hFF, 0, 1, 8'h12, 8'h48, 0, 1, 8'h12, 8'h48, 1);
        push(1, 0, 0, 0, 1, 8'h12, 8'h48, 3'd0, 1);
        push(0, 0, 0, 0, 1, 8'h12, 8'h48, 3'd0, 0);
        push(1, 0, 0, 1, 0, 8'h12, 8'h48, 3'd0, 0);
        // simultaneous drain and completion
        add_word(8'hA5, 0, 0, 8'h12, 8'h48, 0, 1, 8'hA5, 8'hA5, 0);
        add_word(8'h5A, 1, 1, 8'hA5, 8'hA5, 0, 1, 8'h5A, 8'h5A, 0);
        push(1, 0, 0, 1, 0, 8'h5A, 8'h5A, 3'd0, 0);
        // abort after three bits, ignored strobe while disabled, then 0x3C
        push(1, 1, 1, 0, 0, 8'h5A, 8'h5A, 3'd1, 0);
        push(1, 1, 1, 0, 0, 8'h5A, 8'h5A, 3'd2, 0);
        push(1, 1, 1, 0, 0, 8'h5A, 8'h5A, 3'd3, 0);
        push(0, 0, 0, 0, 0, 8'h5A, 8'h5A, 3'd0, 0);
        push(0, 1, 1, 0, 0, 8'h5A, 8'h5A, 3'd0, 0);
        add_word(8'h3C, 0, 0, 8'h5A, 8'h5A, 0, 1, 8'h3C, 8'h3C, 0);
        push(1, 0, 0, 1, 0, 8'h3C, 8'h3C, 3'd0, 0);

        #1;
        chk("rst_valid", 32'(valid_m), 32'd0);
        chk("rst_data", 32'(data_m), 32'd0);
        chk("rst_cnt", 32'(cnt_m), 32'd0);
        chk("rst_busy", 32'(busy_m), 32'd0);
        chk("rst_ovr", 32'(ovr_m), 32'd0);
        #11;
        rst8 = 1'b0;
        rst16 = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en8 = vecs[i].en; smp8 = vecs[i].smp; din8 = vecs[i].din; rdy8 = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid_m", i), 32'(valid_m), 32'(vecs[i].v));
            chk($sformatf("v%0d_valid_l", i), 32'(valid_l), 32'(vecs[i].v));
            chk($sformatf("v%0d_data_m", i), 32'(data_m), 32'(vecs[i].dm));
            chk($sformatf("v%0d_data_l", i), 32'(data_l), 32'(vecs[i].dl));
            chk($sformatf("v%0d_cnt", i), 32'(cnt_m), 32'(vecs[i].c));
            chk($sformatf("v%0d_cnt_l", i), 32'(cnt_l), 32'(vecs[i].c));
            chk($sformatf("v%0d_busy", i), 32'(busy_m), 32'(vecs[i].c != 3'd0));
            chk($sformatf("v%0d_ovr", i), 32'(ovr_m), 32'(vecs[i].o));
            chk($sformatf("v%0d_ovr_l", i), 32'(ovr_l), 32'(vecs[i].o));
        end
        en8 = 1'b0; smp8 = 1'b0; rdy8 = 1'b0;

        // 16-bit word streamed with sample held high
        w16 = 16'hBEEF;
        en16 = 1'b1;
        smp16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            din16 = w16[15-i];
            @(posedge clk);
            #1;
            if (i == 8) chk("w16_cnt9", 32'(cnt16), 32'd9);
            if (i == 14) chk("w16_valid_early", 32'(valid16), 32'd0);
        end
        chk("w16_valid", 32'(valid16), 32'd1);
        chk("w16_data", 32'(data16), 32'hBEEF);
        chk("w16_cnt0", 32'(cnt16), 32'd0);

        // second pass, async reset after bit 9 with the first word still held
        for (int i = 0; i < 9; i++) begin
            din16 = w16[15-i];
            @(posedge clk);
            #1;
        end
        smp16 = 1'b0;
        chk("w16b_cnt9", 32'(cnt16), 32'd9);
        chk("w16b_busy", 32'(busy16), 32'd1);
        chk("w16b_held", 32'(valid16), 32'd1);
        #2;
        rst16 = 1'b1;
        #1;
        chk("arst_valid", 32'(valid16), 32'd0);
        chk("arst_data", 32'(data16), 32'd0);
        chk("arst_cnt", 32'(cnt16), 32'd0);
        chk("arst_busy", 32'(busy16), 32'd0);
        chk("arst_ovr", 32'(ovr16), 32'd0);
        @(negedge clk);
        rst16 = 1'b0;
        en16 = 1'b0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
